divider46_seq: RTL and testbench
================================

Name: divider46_seq

Overview:
- Sequential unsigned radix-2 restoring divider for 46-bit operands; the inverse-operation counterpart to the 46x46 Karatsuba multiplier in the double-precision datapath.
- Serves the FP divide path: mantissa quotient/remainder generation feeding normalisation and rounding.
- Single start/ready handshake, one quotient bit per clock, fixed latency independent of operand values.

Parameters:
- W, 46, operand/quotient/remainder width in bits (min 2).
- CW, 6, iteration counter width; must satisfy 2^CW > W.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- start  input  1  request pulse; sampled only in IDLE.
- x  input  W  dividend; captured on accepted start.
- y  input  W  divisor; captured on accepted start.
- quotient  output  W  floor(x/y); registered, held until next accepted start.
- remainder  output  W  x mod y; registered, held until next accepted start.
- ready  output  1  one-cycle pulse: results valid.
- busy  output  1  high from accepted start until the ready cycle inclusive.
- div_by_zero  output  1  flag for the current result; held with the results.
- sticky  output  1  see Optional Feature.

Behaviour:
- Reset (reset low, async): state=IDLE; quotient, remainder, ready, busy, div_by_zero, sticky = 0; counter and internal registers = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and y!=0: latch x into shift register Q, y into D; clear partial remainder R (W+1 bits); counter=W; busy=1; go RUN.
  - start=1 and y==0: go DONE with quotient = all ones, remainder = x, div_by_zero=1.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - {R,Q} shifted left 1.
  - T = R - {1'b0,D}, computed W+1 bits wide.
  - T non-negative: R=T, Q[0]=1. Otherwise R unchanged, Q[0]=0.
  - counter decrements; on the cycle counter reaches 1, go DONE.
- DONE (one cycle):
  - quotient=Q, remainder=R[W-1:0], ready=1, busy=1.
  - div_by_zero=0 for a normal divide.
  - Next cycle: IDLE with busy=0, ready=0.
- Latency:
  - Start sampled at edge 0, y!=0: ready high in the cycle after edge W+1 (47 for W=46).
  - y==0: ready high after edge 1.
- start while busy=1 (RUN or DONE) is ignored; it is neither queued nor latched.
- start in the IDLE cycle immediately after DONE is accepted normally, allowing back-to-back operations every W+2 cycles.
- Output registers change only on entry to DONE or on reset; between operations they hold their last values.
- x, y are don't-care except in the accepting cycle.
- Reset mid-RUN aborts the operation. No ready pulse is emitted and all outputs clear.
- x<y gives quotient=0, remainder=x. x==0 gives quotient=0, remainder=0.
- Width rule: R is W+1 bits so the shift cannot overflow before the subtract; no result is truncated.

Optional Feature:
- Macro: DIV46_STICKY_EN.
- Defined: sticky is registered on entry to DONE as (R!=0) for a normal divide and 1 for divide-by-zero; held with the other results; cleared by reset.
- Undefined: sticky is tied to 0 and no extra logic is built.

Test Plan:
- x=100, y=7, start pulse -> busy high for 47 cycles, ready pulse at cycle 47, quotient=14, remainder=2, div_by_zero=0, sticky=1 (if enabled).
- x=2^46-1, y=1 -> quotient=2^46-1, remainder=0, sticky=0. Then x=2^46-1, y=2^46-1 back-to-back in the first IDLE cycle -> quotient=1, remainder=0.
- x=5, y=9 -> quotient=0, remainder=5. Then x=0, y=3 -> quotient=0, remainder=0.
- x=1234, y=0 -> ready at cycle 2, quotient=all ones, remainder=1234, div_by_zero=1. The next normal divide clears div_by_zero.
- start x=100, y=7; second start with x=50, y=5 at cycle 10 -> ignored, results 14/2 at cycle 47.
- start x=100, y=7; reset low at cycle 20 -> all outputs 0 immediately, no ready pulse. After reset high, x=81, y=9 -> quotient=9, remainder=0.

Source files
------------

// File: rtl/divider46_seq.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, fixed latency.
// Optional DIV46_STICKY_EN adds a registered inexact (nonzero remainder) flag.
module divider46_seq #(
  parameter int W  = 46,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         ready,
  output logic         busy,
  output logic         div_by_zero,
  output logic         sticky
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [W:0]    r_r;
  logic [W-1:0]  q_r;
  logic [W-1:0]  d_r;
  logic [CW-1:0] cnt_r;
  logic          dz_r;
  logic [W:0]    shift_s;
  logic [W:0]    diff_s;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    shift_s = {r_r[W-1:0], q_r[W-1]};
    diff_s  = shift_s - {1'b0, d_r};
  end

  // Control FSM, datapath iteration and registered result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      r_r         <= {(W+1){1'b0}};
      q_r         <= {W{1'b0}};
      d_r         <= {W{1'b0}};
      cnt_r       <= {CW{1'b0}};
      dz_r        <= 1'b0;
      quotient    <= {W{1'b0}};
      remainder   <= {W{1'b0}};
      ready       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ready <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (y != {W{1'b0}}) begin
              q_r     <= x;
              d_r     <= y;
              r_r     <= {(W+1){1'b0}};
              cnt_r   <= CW'(W);
              dz_r    <= 1'b0;
              state_r <= RUN;
            end else begin
              // Divide-by-zero preloads the saturated result and skips iteration
              q_r     <= {W{1'b1}};
              r_r     <= {1'b0, x};
              d_r     <= {W{1'b0}};
              cnt_r   <= {CW{1'b0}};
              dz_r    <= 1'b1;
              state_r <= DONE;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (!diff_s[W]) begin
            r_r <= diff_s;
            q_r <= {q_r[W-2:0], 1'b1};
          end else begin
            r_r <= shift_s;
            q_r <= {q_r[W-2:0], 1'b0};
          end
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          quotient    <= q_r;
          remainder   <= r_r[W-1:0];
          div_by_zero <= dz_r;
          ready       <= 1'b1;
          busy        <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          ready   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV46_STICKY_EN
  // Inexact flag captured alongside the other results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky <= 1'b0;
    end else if (state_r == DONE) begin
      sticky <= dz_r | (r_r != {(W+1){1'b0}});
    end else begin
      sticky <= sticky;
    end
  end
`else
  assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_divider46_seq.sv
// Scoreboard bench for divider46_seq: directed vectors, queue-based result checking.
module tb_divider46_seq;
  localparam int W = 46;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         ready;
  logic         busy;
  logic         div_by_zero;
  logic         sticky;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         st;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};

  divider46_seq #(.W(W), .CW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
    .quotient(quotient), .remainder(remainder), .ready(ready),
    .busy(busy), .div_by_zero(div_by_zero), .sticky(sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the following negedge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input logic est);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
`ifdef DIV46_STICKY_EN
    e.st  = est;
`else
    e.st  = 1'b0;
`endif
    e.cyc = cyc + 1 + ((b == {W{1'b0}}) ? 1 : (W + 1));
    sb.push_back(e);
    start = 1'b1;
    x = a;
    y = b;
    @(negedge clk);
    start = 1'b0;
    x = {W{1'b0}};
    y = {W{1'b0}};
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < W + 10) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
    chk("busy_low_idle", 64'(busy), 64'd0);
  endtask

  // Monitor: pops the expected result whenever the DUT presents one
  always @(negedge clk) begin
    if (reset && ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 64'(ready), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        chk("sticky", 64'(sticky), 64'(e.st));
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
        chk("busy_at_ready", 64'(busy), 64'd1);
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    x = {W{1'b0}};
    y = {W{1'b0}};
    repeat (3) @(negedge clk);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    chk("rst_sticky", 64'(sticky), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(46'd100, 46'd7, 46'd14, 46'd2, 1'b0, 1'b1);
    chk("busy_after_start", 64'(busy), 64'd1);
    drain();

    // Back-to-back: second start in the ready cycle
    issue(ONES, 46'd1, ONES, 46'd0, 1'b0, 1'b0);
    wait_ready();
    issue(ONES, ONES, 46'd1, 46'd0, 1'b0, 1'b0);
    drain();

    issue(46'd5, 46'd9, 46'd0, 46'd5, 1'b0, 1'b1);
    drain();
    issue(46'd0, 46'd3, 46'd0, 46'd0, 1'b0, 1'b0);
    drain();
    issue(46'd35184372088832, 46'd3, 46'd11728124029610, 46'd2, 1'b0, 1'b1);
    drain();

    issue(46'd1234, 46'd0, ONES, 46'd1234, 1'b1, 1'b1);
    drain();
    issue(46'd1000, 46'd3, 46'd333, 46'd1, 1'b0, 1'b1);
    drain();

    // A start while busy must be ignored
    issue(46'd100, 46'd7, 46'd14, 46'd2, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    chk("busy_during_run", 64'(busy), 64'd1);
    start = 1'b1;
    x = 46'd50;
    y = 46'd5;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-run aborts with no ready pulse
    issue(46'd100, 46'd7, 46'd14, 46'd2, 1'b0, 1'b1);
    repeat (19) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_remainder", 64'(remainder), 64'd0);
    chk("abort_ready", 64'(ready), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_dz", 64'(div_by_zero), 64'd0);
    chk("abort_sticky", 64'(sticky), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    issue(46'd81, 46'd9, 46'd9, 46'd0, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
